lcd_writer: RTL

//  Downstream of the CPU's memory-mapped LCD port. Replaces CPU bit-banging of
//  lcd_data/lcd_ctrl/lcd_enable. Buffers command/data bytes in a small FIFO and

---
 rtl/lcd_writer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/lcd_writer.sv
// rtl/lcd_writer.sv - FIFO-buffered HD44780-style LCD write sequencer
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   wr_en, wr_is_data,  push a byte (wr_is_data=1 -> rs=1 data write,
//   wr_data[7:0]          0 -> rs=0 command write)
//   full                FIFO holds FIFO_DEPTH entries
//   busy                FIFO non-empty or sequencer not idle
//   lcd_data[7:0],      LCD bus; lcd_rw is tied low (write only)
//   lcd_rs, lcd_rw,
//   lcd_en
//
// Optional feature macro: LCD_WRITER_SIM_PRINT_EN echoes each data byte to the
// simulation console on the falling edge of lcd_en.
module lcd_writer #(
  parameter int FIFO_DEPTH       = 8,
  parameter int SETUP_CYCLES     = 2,
  parameter int PULSE_CYCLES     = 4,
  parameter int HOLD_CYCLES      = 2,
  parameter int EXEC_CYCLES      = 50,
  parameter int LONG_EXEC_CYCLES = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       wr_is_data,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       busy,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int MAX_A = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_B = (HOLD_CYCLES > EXEC_CYCLES) ? HOLD_CYCLES : EXEC_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > LONG_EXEC_CYCLES) ? MAX_C : LONG_EXEC_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC} state_t;

  // FIFO entries are {rs, data}
  logic [8:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;
  logic [8:0]       head;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             long_q;
  logic             head_long;

  assign full   = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign busy   = (count != '0) || (state != S_IDLE);
  assign lcd_rw = 1'b0;
  assign push   = wr_en && !full;
  assign head   = mem[rd_ptr];
  // Clear display (0x01) and return home (0x02/0x03) need the long wait
  assign head_long = !head[8] && (head[7:0] == 8'h01 || head[7:0] == 8'h02 ||
                                  head[7:0] == 8'h03);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_is_data, wr_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lcd_en   <= 1'b0;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      // Registered strobe so lcd_en is glitch-free at the pin
      lcd_en <= (state_next == S_PULSE);
      if (pop) begin
        lcd_rs   <= head[8];
        lcd_data <= head[7:0];
        long_q   <= head_long;
      end
    end
  end

  // The shared counter is loaded with N-1 on entry so each state lasts N cycles
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = S_SETUP;
          cnt_next   = CNT_W'(SETUP_CYCLES - 1);
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_next = S_PULSE;
          cnt_next   = CNT_W'(PULSE_CYCLES - 1);
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt == '0) begin
          state_next = S_HOLD;
          cnt_next   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          state_next = S_EXEC;
          cnt_next   = long_q ? CNT_W'(LONG_EXEC_CYCLES - 1) : CNT_W'(EXEC_CYCLES - 1);
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_EXEC: begin
        if (cnt == '0) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef LCD_WRITER_SIM_PRINT_EN
  always @(negedge lcd_en) begin
    if (rst_n && lcd_rs) $write("%c", lcd_data);
  end
`else
`endif

endmodule
